// File: rtl/dccm_ldst_ctrl.sv
// DCCM load/store port controller: checks requests, drives the RAM and
// returns aligned load data in order through a credit-protected response FIFO.
module dccm_ldst_ctrl #(
    parameter logic [31:0] DCCM_BASE = 32'h00800000,
    parameter int unsigned A_WIDTH   = 17,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_a,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_wr,
    input  logic [1:0]         req_size,
    input  logic               req_sext,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_data,
    output logic               rsp_err,
    output logic [A_WIDTH-1:0] dccm_addr,
    output logic [31:0]        dccm_wr_data,
    output logic [3:0]         dccm_we,
    output logic [3:0]         dccm_ck_en,
    input  logic [31:0]        dccm_rd_data
);

    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PW = $clog2(RSP_DEPTH);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSV  = 2'd3
    } size_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc, pop, push, err;
    logic [3:0]    mask;
    size_e         size;

    logic          s1_valid_q, s1_wr_q, s1_sext_q, s1_err_q;
    size_e         s1_size_q;
    logic [1:0]    s1_addr_q;
    logic [31:0]   ld_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    logic [31:0]   fdata_q [RSP_DEPTH];
    logic          ferr_q  [RSP_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] fcnt_q, fcnt_d;

    assign size      = size_e'(req_size);
    assign req_ready = rst_a & (cnt_q < CW'(RSP_DEPTH));
    assign acc       = req_valid & req_ready;
    assign rsp_valid = (fcnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign push      = s1_valid_q;

    always_comb begin
        err  = 1'b0;
        mask = 4'b0000;
        dccm_wr_data = req_wdata;
        case (size)
            SZ_BYTE: begin
                mask         = 4'b0001 << req_addr[1:0];
                dccm_wr_data = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                mask         = 4'b0011 << {req_addr[1], 1'b0};
                dccm_wr_data = {2{req_wdata[15:0]}};
                err          = req_addr[0];
            end
            SZ_WORD: begin
                mask = 4'b1111;
                err  = (req_addr[1:0] != 2'b00);
            end
            default: err = 1'b1;
        endcase
        if (req_addr[31:A_WIDTH+2] != DCCM_BASE[31:A_WIDTH+2]) begin
            err = 1'b1;
        end
    end

    assign dccm_addr  = req_addr[A_WIDTH+1:2];
    assign dccm_ck_en = (acc & ~err) ? mask : 4'b0000;
    assign dccm_we    = (acc & ~err & req_wr) ? mask : 4'b0000;

    always_comb begin
        cnt_d = cnt_q + CW'(acc) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_wr_q    <= 1'b0;
            s1_sext_q  <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_size_q  <= SZ_BYTE;
            s1_addr_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            s1_valid_q <= acc;
            if (acc) begin
                s1_wr_q   <= req_wr;
                s1_sext_q <= req_sext;
                s1_err_q  <= err;
                s1_size_q <= size;
                s1_addr_q <= req_addr[1:0];
            end
        end
    end

    // RAM output arrives in the cycle after acceptance; align it against the stage-1 copy.
    assign ld_byte = dccm_rd_data[{s1_addr_q, 3'b000} +: 8];
    assign ld_half = dccm_rd_data[{s1_addr_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = '0;
        case (s1_size_q)
            SZ_BYTE: ld_data = {{24{s1_sext_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{s1_sext_q & ld_half[15]}}, ld_half};
            SZ_WORD: ld_data = dccm_rd_data;
            default: ld_data = '0;
        endcase
        if (s1_wr_q || s1_err_q) begin
            ld_data = '0;
        end
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
        fcnt_d = fcnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fcnt_q <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fdata_q[wptr_q] <= ld_data;
            ferr_q[wptr_q]  <= s1_err_q;
        end
    end

    assign rsp_data = rsp_valid ? fdata_q[rptr_q] : '0;
    assign rsp_err  = rsp_valid ? ferr_q[rptr_q]  : 1'b0;

endmodule

// File: tb/tb_dccm_ldst_ctrl.sv
// Scoreboard bench for dccm_ldst_ctrl: byte-level reference memory, RAM model,
// directed test-plan cases followed by randomized traffic.
module tb_dccm_ldst_ctrl;

    localparam logic [31:0] BASE   = 32'h00800000;
    localparam logic [31:0] WIN_SZ = 32'h00080000;

    logic        clk, rst_a;
    logic        req_valid, req_ready, req_wr, req_sext;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic [16:0] dccm_addr;
    logic [31:0] dccm_wr_data, dccm_rd_data;
    logic [3:0]  dccm_we, dccm_ck_en;

    dccm_ldst_ctrl #(
        .DCCM_BASE(BASE),
        .A_WIDTH  (17),
        .RSP_DEPTH(2)
    ) dut (
        .clk         (clk),
        .rst_a       (rst_a),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_size    (req_size),
        .req_sext    (req_sext),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .dccm_addr   (dccm_addr),
        .dccm_wr_data(dccm_wr_data),
        .dccm_we     (dccm_we),
        .dccm_ck_en  (dccm_ck_en),
        .dccm_rd_data(dccm_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: synchronous read, byte-enabled write.
    logic [31:0] ram [logic [16:0]];
    logic [31:0] ram_w;
    initial dccm_rd_data = 32'h0;
    always @(posedge clk) begin
        if (|dccm_ck_en) begin
            ram_w = ram.exists(dccm_addr) ? ram[dccm_addr] : 32'h0;
            dccm_rd_data <= ram_w;
            for (int i = 0; i < 4; i++)
                if (dccm_we[i]) ram_w[8*i +: 8] = dccm_wr_data[8*i +: 8];
            if (|dccm_we) ram[dccm_addr] = ram_w;
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;
    exp_t q[$];
    logic [7:0] refm [logic [31:0]];
    int   last_pop = -10;
    logic in_reset = 1'b1;
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [7:0] rb(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : 8'h00;
    endfunction

    function automatic logic exp_err(input logic [1:0] sz, input logic [31:0] a);
        int nb = 1 << sz;
        if (sz == 2'd3) return 1'b1;
        if ((a % nb) != 0) return 1'b1;
        return !(a >= BASE && a < BASE + WIN_SZ);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sext,
                                             input logic [31:0] a);
        int nb = 1 << sz;
        logic [31:0] v = '0;
        for (int i = 0; i < nb; i++) v |= 32'(rb(a + i)) << (8 * i);
        if (sext && nb < 4 && v[8*nb-1]) v |= ~((32'd1 << (8 * nb)) - 1);
        return v;
    endfunction

    // One request window: drive at negedge, check RAM-side outputs, book acceptance.
    task automatic cyc1(input logic v, input logic wr, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] w, input logic rr,
                        output logic accepted);
        logic        e, exp_rdy;
        logic [3:0]  m;
        logic [31:0] wd;
        exp_t        ent;
        int          nb;
        @(negedge clk);
        req_valid = v; req_wr = wr; req_size = sz; req_sext = sx;
        req_addr = a; req_wdata = w; rsp_ready = rr;
        #1;
        exp_rdy  = (q.size() < 2);
        chk("req_ready", {31'b0, req_ready}, {31'b0, exp_rdy});
        accepted = v && exp_rdy;
        e  = exp_err(sz, a);
        nb = 1 << sz;
        m  = 4'(((1 << nb) - 1) << a[1:0]);
        chk("dccm_ck_en", {28'b0, dccm_ck_en}, (accepted && !e) ? {28'b0, m} : 32'h0);
        chk("dccm_we", {28'b0, dccm_we}, (accepted && !e && wr) ? {28'b0, m} : 32'h0);
        if (v) begin
            chk("dccm_addr", {15'b0, dccm_addr}, (a % WIN_SZ) / 4);
            if (sz != 2'd3) begin
                wd = w;
                if (nb == 1) wd = {4{w[7:0]}};
                if (nb == 2) wd = {2{w[15:0]}};
                chk("dccm_wr_data", dccm_wr_data, wd);
            end
        end
        if (accepted) begin
            ent.err  = e;
            ent.acc  = cyc;
            ent.data = (e || wr) ? 32'h0 : ref_load(sz, sx, a);
            q.push_back(ent);
            if (!e && wr)
                for (int i = 0; i < nb; i++) refm[a + i] = 8'(w >> (8 * i));
        end
    endtask

    // Hold a request until accepted; rsp_ready stays low for the first 'hold' windows.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] w, input int hold);
        logic ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) cyc1(1'b1, wr, sz, sx, a, w, (i >= hold), ok);
        if (!ok) chk("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic idle(input int n, input logic rr);
        logic ok;
        for (int i = 0; i < n; i++) cyc1(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, rr, ok);
    endtask

    // Monitor: head becomes visible 2 cycles after acceptance, or 1 after the previous pop.
    initial begin
        int   vis;
        logic exp_v;
        forever begin
            @(negedge clk);
            #2;
            if (!in_reset) begin
                exp_v = 1'b0;
                if (q.size() > 0) begin
                    vis   = (q[0].acc + 2 > last_pop + 1) ? q[0].acc + 2 : last_pop + 1;
                    exp_v = (cyc >= vis);
                end
                chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
                if (exp_v) begin
                    chk("rsp_data", rsp_data, q[0].data);
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, q[0].err});
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        last_pop = cyc;
                    end
                end
            end
        end
    end

    task automatic reset_checks();
        chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        chk("rst_we", {28'b0, dccm_we}, 32'h0);
        chk("rst_ck_en", {28'b0, dccm_ck_en}, 32'h0);
    endtask

    initial begin
        logic        ok, v, wr, sx, rr;
        logic [1:0]  sz;
        logic [31:0] a;
        rst_a = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0;
        req_sext = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1 reset_checks();
        @(negedge clk);
        rst_a = 1'b1; in_reset = 1'b0;

        // Word store/load round trip.
        issue(1'b1, 2'd2, 1'b0, 32'h00800010, 32'hDEADBEEF, 0);
        issue(1'b0, 2'd2, 1'b0, 32'h00800010, 32'h0, 0);
        idle(3, 1'b1);
        // Byte store and sign/zero-extended reads across lanes.
        issue(1'b1, 2'd0, 1'b0, 32'h00800013, 32'h000000A5, 0);
        issue(1'b0, 2'd0, 1'b1, 32'h00800013, 32'h0, 0);
        issue(1'b0, 2'd0, 1'b0, 32'h00800013, 32'h0, 0);
        issue(1'b0, 2'd1, 1'b1, 32'h00800012, 32'h0, 0);
        // Error cases.
        issue(1'b0, 2'd1, 1'b0, 32'h00800001, 32'h0, 0);
        issue(1'b1, 2'd2, 1'b0, 32'h00800002, 32'h12345678, 0);
        issue(1'b0, 2'd2, 1'b0, 32'h00000000, 32'h0, 0);
        issue(1'b0, 2'd3, 1'b0, 32'h00800010, 32'h0, 0);
        issue(1'b0, 2'd2, 1'b0, BASE + WIN_SZ, 32'h0, 0);
        idle(3, 1'b1);
        // Backpressure: two loads fill the credits, the third waits for a pop.
        issue(1'b0, 2'd2, 1'b0, 32'h00800010, 32'h0, 100);
        issue(1'b0, 2'd0, 1'b0, 32'h00800011, 32'h0, 100);
        issue(1'b0, 2'd1, 1'b0, 32'h00800012, 32'h0, 3);
        idle(4, 1'b1);
        // Reset with one response queued and one in stage 1.
        issue(1'b0, 2'd2, 1'b0, 32'h00800010, 32'h0, 100);
        issue(1'b0, 2'd2, 1'b0, 32'h00800010, 32'h0, 100);
        @(negedge clk);
        req_valid = 1'b0; rst_a = 1'b0; in_reset = 1'b1;
        q.delete(); last_pop = -10;
        #1 reset_checks();
        repeat (2) @(negedge clk);
        rst_a = 1'b1; in_reset = 1'b0;
        #1 chk("post_rst_ready", {31'b0, req_ready}, 32'h1);
        idle(5, 1'b1);

        // Randomized traffic, including window-edge and out-of-window addresses.
        for (int n = 0; n < 800; n++) begin
            v  = ($urandom % 4) != 0;
            rr = ($urandom % 4) != 0;
            wr = $urandom % 2;
            sx = $urandom % 2;
            sz = 2'($urandom % 4);
            case ($urandom % 8)
                0:       a = $urandom;
                1:       a = 32'h0;
                2:       a = BASE + WIN_SZ - 4 + ($urandom % 8);
                default: a = BASE + ($urandom % 24);
            endcase
            cyc1(v, wr, sz, sx, a, $urandom, rr, ok);
        end
        idle(6, 1'b1);
        chk("drained", q.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
